// File: rtl/mem_arbiter_2to1_if.sv
// Memory-controller request/response types and the arbiter's bus bundle.
// Cache/memory side uses the master modport, the arbiter uses slave.
package memory_controller_interface;
  localparam int unsigned MCI_ADDR_LENGTH = 32;
  localparam int unsigned MCI_DATA_LENGTH = 128;

  typedef struct packed {
    logic [MCI_ADDR_LENGTH-1:0] addr;
    logic [MCI_DATA_LENGTH-1:0] data;
    logic                       rw;
    logic                       valid;
  } mci_request_t;

  typedef struct packed {
    logic [MCI_DATA_LENGTH-1:0] data;
    logic                       ready;
  } mci_response_t;
endpackage

interface mem_arbiter_2to1_if;
  import memory_controller_interface::*;

  mci_request_t  ireq;
  mci_request_t  dreq;
  mci_request_t  mreq;
  mci_response_t ires;
  mci_response_t dres;
  mci_response_t mres;
  logic          busy;
  logic          err;

  modport slave (
    input  ireq, dreq, mres,
    output ires, dres, mreq, busy, err
  );

  modport master (
    output ireq, dreq, mres,
    input  ires, dres, mreq, busy, err
  );
endinterface

// File: rtl/mem_arbiter_2to1.sv
// Two-port (I-cache / D-cache) arbiter onto a single memory controller port.
// Define MEM_ARB_DCACHE_PRIO_EN for fixed D-port priority on ties; default is round-robin.
module mem_arbiter_2to1
  import memory_controller_interface::*;
(
  input  logic                 clk,
  input  logic                 rst,
  mem_arbiter_2to1_if.slave    bus
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  state_t       state, state_nxt;
  logic         owner, owner_nxt;
  logic         grant;
  logic         done;
  logic         i_done, d_done;
  logic         err_q;
  // Buffer .valid doubles as the pending flag.
  mci_request_t ibuf, dbuf;

`ifndef MEM_ARB_DCACHE_PRIO_EN
  logic         last_grant, last_grant_nxt;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= PORT_I;
`ifndef MEM_ARB_DCACHE_PRIO_EN
      last_grant <= PORT_I;
`endif
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
`ifndef MEM_ARB_DCACHE_PRIO_EN
      last_grant <= last_grant_nxt;
`endif
    end
  end

  // Next-state, grant and bus outputs; responses pass straight through
  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
`ifndef MEM_ARB_DCACHE_PRIO_EN
    last_grant_nxt = last_grant;
`endif
    done           = 1'b0;
    bus.mreq       = '0;
    bus.ires.data  = bus.mres.data;
    bus.ires.ready = 1'b0;
    bus.dres.data  = bus.mres.data;
    bus.dres.ready = 1'b0;
    bus.busy       = 1'b0;

    if (ibuf.valid && dbuf.valid) begin
`ifdef MEM_ARB_DCACHE_PRIO_EN
      grant = PORT_D;
`else
      grant = ~last_grant;
`endif
    end else begin
      grant = dbuf.valid ? PORT_D : PORT_I;
    end

    case (state)
      IDLE: begin
        if (ibuf.valid || dbuf.valid) begin
          bus.mreq  = (grant == PORT_D) ? dbuf : ibuf;
          state_nxt = WAIT;
          owner_nxt = grant;
`ifndef MEM_ARB_DCACHE_PRIO_EN
          last_grant_nxt = grant;
`endif
        end
      end
      WAIT: begin
        bus.mreq       = (owner == PORT_D) ? dbuf : ibuf;
        bus.mreq.valid = 1'b0;
        bus.busy       = 1'b1;
        if (bus.mres.ready) begin
          done           = 1'b1;
          bus.ires.ready = (owner == PORT_I);
          bus.dres.ready = (owner == PORT_D);
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign i_done  = done && (owner == PORT_I);
  assign d_done  = done && (owner == PORT_D);
  assign bus.err = err_q;

  // Pending buffers and sticky error; a reload on completion wins over the clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ibuf  <= '0;
      dbuf  <= '0;
      err_q <= 1'b0;
    end else begin
      if (bus.ireq.valid && (!ibuf.valid || i_done)) ibuf <= bus.ireq;
      else if (i_done)                               ibuf.valid <= 1'b0;

      if (bus.dreq.valid && (!dbuf.valid || d_done)) dbuf <= bus.dreq;
      else if (d_done)                               dbuf.valid <= 1'b0;

      if ((bus.ireq.valid && ibuf.valid && !i_done) ||
          (bus.dreq.valid && dbuf.valid && !d_done) ||
          ((state == IDLE) && bus.mres.ready))
        err_q <= 1'b1;
    end
  end

endmodule
